// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the five-stage RV32IMF core.
//
// Owns the fetch PC, issues word requests to instruction memory, tags each
// returned word with its PC, parks it in a 2-entry fetch buffer (or bypasses
// it straight into decode) and presents one {instruction, pc, pc+4} triple
// per cycle to id_stage.
//
// Handshakes:
//   Instruction memory: a request is accepted in any cycle where
//   i_req_o & i_gnt_i. While i_req_o is high and i_gnt_i is low, i_addr_o
//   stays stable. Read data returns with i_rvalid_i exactly one cycle after
//   acceptance.
//   Decode: the d_* register advances whenever neither stall input is high;
//   d_valid_o marks a real instruction, otherwise d_instruction_o is a bubble.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   stall_i               load-use stall from decode (holds decode register)
//   stall_general_i       multi-cycle ALU stall (holds decode register)
//   brj_i, brj_pc_i       taken branch/jump and its target
//   i_req_o, i_addr_o     instruction-memory request and word address
//   i_gnt_i               request accepted this cycle
//   i_rvalid_i, i_rdata_i returned instruction word
//   d_instruction_o       instruction to decode
//   d_pc_o, d_pc4_o       its PC and PC+4
//   d_valid_o             1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        stall_general_i,
   input  logic        brj_i,
   input  logic [31:0] brj_pc_i,
   output logic        i_req_o,
   output logic [31:0] i_addr_o,
   input  logic        i_gnt_i,
   input  logic        i_rvalid_i,
   input  logic [31:0] i_rdata_i,
   output logic [31:0] d_instruction_o,
   output logic [31:0] d_pc_o,
   output logic [31:0] d_pc4_o,
   output logic        d_valid_o
);

   logic [31:0] fpc;
   logic [31:0] pend_pc;
   logic        outstanding;
   logic        drop;

   // Fetch buffer: 2 entries of {pc, instruction}, separate read/write pointers.
   logic [31:0] fb_pc    [2];
   logic [31:0] fb_instr [2];
   logic        fb_rp;
   logic        fb_wp;
   logic [1:0]  fb_count;

   logic        hold;
   logic        advance;
   logic        redirect;
   logic        resp_ok;
   logic        fb_empty;
   logic        pop_fb;
   logic        bypass;
   logic        pop;
   logic        push;
   logic        accept;
   logic [2:0]  occ;
   logic [2:0]  occ_limit;

   assign hold     = stall_i | stall_general_i;
   assign advance  = ~hold;
   // Branch outcome is only trusted when decode actually advances; during a
   // hold its operands may be stale.
   assign redirect = brj_i & advance;

   // A response is usable only if we are waiting for one and it is not the
   // tail of a flushed fetch. Unsolicited rvalids fall out here as well.
   assign resp_ok  = i_rvalid_i & outstanding & ~drop;
   assign fb_empty = (fb_count == 2'd0);

   assign pop_fb   = advance & ~redirect & ~fb_empty;
   assign bypass   = advance & ~redirect & fb_empty & resp_ok;
   assign pop      = pop_fb | bypass;
   assign push     = resp_ok & ~redirect & ~bypass;

   // Only request when the word is guaranteed a slot: buffered plus in-flight
   // entries, minus what leaves this cycle, must stay below 2.
   assign occ       = {1'b0, fb_count} + {2'b00, outstanding};
   assign occ_limit = 3'd2 + {2'b00, pop};
   assign i_req_o   = rst_n & ~redirect & (occ < occ_limit);
   assign i_addr_o  = fpc;
   assign accept    = i_req_o & i_gnt_i;

   // Fetch PC, request tracking and flush bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpc         <= BOOT_ADDR;
         pend_pc     <= 32'h0;
         outstanding <= 1'b0;
         drop        <= 1'b0;
      end else begin
         if (redirect)
            fpc <= brj_pc_i;
         else if (accept)
            fpc <= fpc + 32'd4;

         if (accept)
            pend_pc <= fpc;

         if (accept)
            outstanding <= 1'b1;
         else if (i_rvalid_i)
            outstanding <= 1'b0;

         // A request still in flight across a redirect belongs to the old
         // path; its response must be discarded when it finally shows up.
         // A response arriving in the redirect cycle itself is simply not
         // stored, so no drop is needed for it.
         if (redirect && outstanding && !i_rvalid_i)
            drop <= 1'b1;
         else if (i_rvalid_i)
            drop <= 1'b0;
      end
   end

   // Fetch buffer pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb_rp    <= 1'b0;
         fb_wp    <= 1'b0;
         fb_count <= 2'd0;
      end else if (redirect) begin
         fb_rp    <= 1'b0;
         fb_wp    <= 1'b0;
         fb_count <= 2'd0;
      end else begin
         if (push)
            fb_wp <= ~fb_wp;
         if (pop_fb)
            fb_rp <= ~fb_rp;
         fb_count <= fb_count + {1'b0, push} - {1'b0, pop_fb};
      end
   end

   // Buffer payload carries no reset; entries are only read when counted.
   always_ff @(posedge clk) begin
      if (push) begin
         fb_pc[fb_wp]    <= pend_pc;
         fb_instr[fb_wp] <= i_rdata_i;
      end
   end

   // Decode register. Bubbles keep the last PC so decode sees stable values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_instruction_o <= NOP_INSTR;
         d_pc_o          <= 32'h0;
         d_pc4_o         <= 32'h0;
         d_valid_o       <= 1'b0;
      end else if (advance) begin
         if (pop_fb) begin
            d_instruction_o <= fb_instr[fb_rp];
            d_pc_o          <= fb_pc[fb_rp];
            d_pc4_o         <= fb_pc[fb_rp] + 32'd4;
            d_valid_o       <= 1'b1;
         end else if (bypass) begin
            d_instruction_o <= i_rdata_i;
            d_pc_o          <= pend_pc;
            d_pc4_o         <= pend_pc + 32'd4;
            d_valid_o       <= 1'b1;
         end else begin
            // Redirect or nothing available: insert a bubble.
            d_instruction_o <= NOP_INSTR;
            d_valid_o       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// A one-cycle-latency instruction memory answers accepted requests. Expected
// decode PCs are queued by each scenario; every new valid decode instruction
// pops one entry and is compared against it (instruction from the memory
// image, pc+4 from the pc). Scenario-specific cycle checks sit in between.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall_i;
  logic        stall_general_i;
  logic        brj_i;
  logic [31:0] brj_pc_i;
  logic        i_req_o;
  logic [31:0] i_addr_o;
  logic        i_gnt_i;
  logic        i_rvalid_i;
  logic [31:0] i_rdata_i;
  logic [31:0] d_instruction_o;
  logic [31:0] d_pc_o;
  logic [31:0] d_pc4_o;
  logic        d_valid_o;

  if_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .stall_general_i (stall_general_i),
    .brj_i           (brj_i),
    .brj_pc_i        (brj_pc_i),
    .i_req_o         (i_req_o),
    .i_addr_o        (i_addr_o),
    .i_gnt_i         (i_gnt_i),
    .i_rvalid_i      (i_rvalid_i),
    .i_rdata_i       (i_rdata_i),
    .d_instruction_o (d_instruction_o),
    .d_pc_o          (d_pc_o),
    .d_pc4_o         (d_pc4_o),
    .d_valid_o       (d_valid_o)
  );

  // scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // driver: end the current cycle, answer an accepted request one cycle
  // later, then score any new valid instruction in decode.
  task automatic tick();
    logic        acc;
    logic        adv;
    logic [31:0] a;
    logic [31:0] e;
    #1;
    acc = rst_n && i_req_o && i_gnt_i;
    a   = i_addr_o;
    adv = !(stall_i || stall_general_i);
    @(posedge clk);
    #1;
    i_rvalid_i = acc;
    i_rdata_i  = acc ? mem_word(a) : 32'h0;
    if (adv && rst_n && d_valid_o) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_pc", d_pc_o, e);
        check_eq("sb_instr", d_instruction_o, mem_word(e));
        check_eq("sb_pc4", d_pc4_o, e + 32'd4);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_instr"}, d_instruction_o, NOP);
    check_eq({tag, "_pc"},    d_pc_o,          32'h0);
    check_eq({tag, "_pc4"},   d_pc4_o,         32'h0);
    check_eq({tag, "_valid"}, 32'(d_valid_o),  32'd0);
    check_eq({tag, "_req"},   32'(i_req_o),    32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; stall_general_i = 1'b0;
    brj_i = 1'b0; brj_pc_i = 32'h0; i_gnt_i = 1'b1;
    i_rvalid_i = 1'b0; i_rdata_i = 32'h0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // ---- boot: C0 is the first cycle with rst_n high
    rst_n = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    #1;
    check_eq("boot_req", 32'(i_req_o), 32'd1);
    check_eq("boot_addr", i_addr_o, 32'h0);
    tick(); tick();                                     // C2
    check_eq("boot_pc_c2", d_pc_o, 32'h0);
    check_eq("boot_pc4_c2", d_pc4_o, 32'h4);
    check_eq("boot_valid_c2", 32'(d_valid_o), 32'd1);
    tick();                                             // C3
    check_eq("boot_pc_c3", d_pc_o, 32'h4);
    check_eq("boot_pc4_c3", d_pc4_o, 32'h8);
    tick();                                             // C4, decode holds 8

    // ---- redirect to 0x100 while decode holds 8
    brj_i = 1'b1; brj_pc_i = 32'h100;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    #1;
    check_eq("redir_req_low", 32'(i_req_o), 32'd0);
    tick();                                             // R+1
    brj_i = 1'b0;
    #1;
    check_eq("redir_bubble1_valid", 32'(d_valid_o), 32'd0);
    check_eq("redir_bubble1_instr", d_instruction_o, NOP);
    check_eq("redir_target_addr", i_addr_o, 32'h100);
    check_eq("redir_target_req", 32'(i_req_o), 32'd1);
    tick();                                             // R+2
    check_eq("redir_bubble2_valid", 32'(d_valid_o), 32'd0);
    check_eq("redir_bubble2_instr", d_instruction_o, NOP);
    tick();                                             // R+3
    check_eq("redir_pc_100", d_pc_o, 32'h100);
    tick();
    check_eq("redir_pc_104", d_pc_o, 32'h104);

    // ---- hold: redirect to 16, then stall 5 cycles while decode shows 16
    brj_i = 1'b1; brj_pc_i = 32'h10;
    exp_q.push_back(32'h10); exp_q.push_back(32'h14); exp_q.push_back(32'h18);
    tick();
    brj_i = 1'b0;
    tick(); tick();
    check_eq("hold_start_pc", d_pc_o, 32'h10);
    stall_general_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k >= 2) check_eq("hold_req_low", 32'(i_req_o), 32'd0);
      check_eq("hold_frozen_pc", d_pc_o, 32'h10);
      check_eq("hold_frozen_valid", 32'(d_valid_o), 32'd1);
      tick();
    end
    stall_general_i = 1'b0;
    #1;
    check_eq("hold_release_pc", d_pc_o, 32'h10);
    tick();
    check_eq("hold_after_pc20", d_pc_o, 32'h14);
    check_eq("hold_after_valid", 32'(d_valid_o), 32'd1);
    exp_q.push_back(32'h1C); exp_q.push_back(32'h20); exp_q.push_back(32'h24);
    tick();
    check_eq("hold_after_pc24", d_pc_o, 32'h18);
    tick();                                             // decode shows 28

    // ---- branch request while held is ignored
    stall_i = 1'b1; brj_i = 1'b1; brj_pc_i = 32'h200;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("hold_brj_fpc", i_addr_o, 32'h28);
      check_eq("hold_brj_pc", d_pc_o, 32'h1C);
      tick();
    end
    stall_i = 1'b0; brj_i = 1'b0;
    tick();
    check_eq("hold_brj_next", d_pc_o, 32'h20);
    tick();
    check_eq("hold_brj_next2", d_pc_o, 32'h24);

    // ---- grant backpressure and PC wrap
    brj_i = 1'b1; brj_pc_i = 32'hFFFF_FFF8;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick();
    brj_i = 1'b0;
    #1;
    check_eq("wrap_first_addr", i_addr_o, 32'hFFFF_FFF8);
    tick();
    i_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("gnt_low_req", 32'(i_req_o), 32'd1);
      check_eq("gnt_low_addr", i_addr_o, 32'hFFFF_FFFC);
      if (k == 1) check_eq("wrap_pc_fff8", d_pc_o, 32'hFFFF_FFF8);
      tick();
    end
    i_gnt_i = 1'b1;
    #1;
    check_eq("gnt_accept_addr", i_addr_o, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_next_addr", i_addr_o, 32'h0);
    tick();
    check_eq("wrap_pc", d_pc_o, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", d_pc4_o, 32'h0);
    tick(); tick();                                     // decode shows 0, then 4

    // ---- reset with a request in flight and the buffer filling
    stall_general_i = 1'b1;
    tick();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    stall_general_i = 1'b0;
    tick();
    rst_n = 1'b1;
    i_rvalid_i = 1'b1;                                  // stale response after reset
    i_rdata_i  = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    #1;
    check_eq("rst_boot_req", 32'(i_req_o), 32'd1);
    check_eq("rst_boot_addr", i_addr_o, 32'h0);
    tick();
    check_eq("rst_stale_dropped", 32'(d_valid_o), 32'd0);
    tick();
    check_eq("rst_pc0", d_pc_o, 32'h0);
    tick();
    check_eq("rst_pc4", d_pc_o, 32'h4);
    check_eq("sb_final_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
